io_responder: RTL and testbench

IO_RESPONDER -- requirements
Module: io_responder

---
 rtl/io_pkg.sv | 26 ++
 rtl/io_sync_edge.sv | 31 +++
 rtl/io_responder.sv | 132 +++++++++++++
 tb/tb_io_responder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared constants for the io_responder slice.
// Holds the register address map, the LFSR seed and tap mask, and the
// LFSR step function. No ports; imported by io_responder.
package io_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned LFSR_W = 16;

  localparam logic [ADDR_W-1:0] ADDR_LED     = 4'h0;
  localparam logic [ADDR_W-1:0] ADDR_SEG     = 4'h1;
  localparam logic [ADDR_W-1:0] ADDR_SW      = 4'h2;
  localparam logic [ADDR_W-1:0] ADDR_BTNEV   = 4'h3;
  localparam logic [ADDR_W-1:0] ADDR_TICKCNT = 4'h4;
  localparam logic [ADDR_W-1:0] ADDR_DIV     = 4'h5;
  localparam logic [ADDR_W-1:0] ADDR_RAND    = 4'h6;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 map to bits 15,13,12,10.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // Fibonacci step: shift left, feed the XOR of the tapped bits into bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/io_sync_edge.sv
// Two-flop synchronizer with a rising-edge detector.
// Ports: CLK, RESET (async, active-high), d (async input),
//        q (synchronized value), rise_c (one-cycle 0->1 pulse of q).
module io_sync_edge #(
  parameter int unsigned W = 1
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise_c
);

  logic [W-1:0] meta;
  logic [W-1:0] prev;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      meta <= '0;
      q    <= '0;
      prev <= '0;
    end else begin
      meta <= d;
      q    <= meta;
      prev <= q;
    end
  end

  assign rise_c = q & ~prev;

endmodule

// File: rtl/io_responder.sv
// Memory-mapped I/O register block: LEDs, display value, switches,
// latched button events, a programmable tick prescaler with tick counter,
// and an optional pseudo-random source.
// Ports: CLK, RESET (async, active-high), IOAddr/IOWriteData/IOWriteEn
//        (processor write port), IOReadData (combinational read),
//        SW/BTN (async inputs), LED/SEG (register contents), TICK (pulse).
// Build option: define IO_RESPONDER_LFSR_EN to include the LFSR behind RAND.
module io_responder
  import io_pkg::*;
#(
  parameter int unsigned DIV_W   = 24,
  parameter int unsigned DIV_RST = 1000000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  IOAddr,
  input  logic [31:0] IOWriteData,
  input  logic        IOWriteEn,
  output logic [31:0] IOReadData,
  input  logic [7:0]  SW,
  input  logic [3:0]  BTN,
  output logic [7:0]  LED,
  output logic [15:0] SEG,
  output logic        TICK
);

  logic [7:0]       sw_sync;
  logic [7:0]       sw_rise_unused;
  logic [3:0]       btn_sync_unused;
  logic [3:0]       btn_rise_c;
  logic [3:0]       btnev;
  logic [31:0]      tickcnt;
  logic [DIV_W-1:0] presc;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_last;
  logic             tick_now;
  logic [3:0]       btn_clr;
  logic [31:0]      rand_val;
  logic             wdata_unused;

  io_sync_edge #(.W(8)) u_sw_sync (
    .CLK    (CLK),
    .RESET  (RESET),
    .d      (SW),
    .q      (sw_sync),
    .rise_c (sw_rise_unused)
  );

  io_sync_edge #(.W(4)) u_btn_sync (
    .CLK    (CLK),
    .RESET  (RESET),
    .d      (BTN),
    .q      (btn_sync_unused),
    .rise_c (btn_rise_c)
  );

  // Upper write-data bits beyond the widest register are not stored.
  assign wdata_unused = ^IOWriteData;

  // DIV=0 behaves as DIV=1: terminal count is 0 either way.
  assign div_last = (div_q == '0) ? '0 : div_q - DIV_W'(1);
  assign tick_now = (presc >= div_last);

  assign btn_clr = (IOWriteEn && IOAddr == ADDR_BTNEV) ? IOWriteData[3:0] : 4'h0;

  // Register file, event latch and prescaler.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      LED     <= '0;
      SEG     <= '0;
      btnev   <= '0;
      tickcnt <= '0;
      presc   <= '0;
      div_q   <= DIV_W'(DIV_RST);
      TICK    <= 1'b0;
    end else begin
      if (IOWriteEn && IOAddr == ADDR_LED) LED <= IOWriteData[7:0];
      if (IOWriteEn && IOAddr == ADDR_SEG) SEG <= IOWriteData[15:0];
      if (IOWriteEn && IOAddr == ADDR_DIV) div_q <= IOWriteData[DIV_W-1:0];

      // A new edge wins over a same-cycle clear.
      btnev <= (btnev & ~btn_clr) | btn_rise_c;

      if (IOWriteEn && IOAddr == ADDR_DIV) begin
        presc <= '0;
        TICK  <= 1'b0;
      end else if (tick_now) begin
        presc <= '0;
        TICK  <= 1'b1;
      end else begin
        presc <= presc + DIV_W'(1);
        TICK  <= 1'b0;
      end

      // A clear wins over a same-cycle tick.
      if (IOWriteEn && IOAddr == ADDR_TICKCNT) begin
        tickcnt <= '0;
      end else if (tick_now && !(IOWriteEn && IOAddr == ADDR_DIV)) begin
        tickcnt <= tickcnt + 32'(1);
      end
    end
  end

`ifdef IO_RESPONDER_LFSR_EN
  logic [LFSR_W-1:0] lfsr_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_next(lfsr_q);
  end

  assign rand_val = 32'(lfsr_q);
`else
  assign rand_val = '0;
`endif

  // Combinational read mux, zero-extended.
  always_comb begin
    IOReadData = '0;
    case (IOAddr)
      ADDR_LED:     IOReadData = 32'(LED);
      ADDR_SEG:     IOReadData = 32'(SEG);
      ADDR_SW:      IOReadData = 32'(sw_sync);
      ADDR_BTNEV:   IOReadData = 32'(btnev);
      ADDR_TICKCNT: IOReadData = tickcnt;
      ADDR_DIV:     IOReadData = 32'(div_q);
      ADDR_RAND:    IOReadData = rand_val;
      default:      IOReadData = '0;
    endcase
  end

endmodule

// File: tb/tb_io_responder.sv
module tb_io_responder;

  logic        CLK;
  logic        RESET;
  logic [3:0]  IOAddr;
  logic [31:0] IOWriteData;
  logic        IOWriteEn;
  logic [31:0] IOReadData;
  logic [7:0]  SW;
  logic [3:0]  BTN;
  logic [7:0]  LED;
  logic [15:0] SEG;
  logic        TICK;

  int n_vec = 0;
  int n_bad = 0;

  io_responder dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .IOAddr      (IOAddr),
    .IOWriteData (IOWriteData),
    .IOWriteEn   (IOWriteEn),
    .IOReadData  (IOReadData),
    .SW          (SW),
    .BTN         (BTN),
    .LED         (LED),
    .SEG         (SEG),
    .TICK        (TICK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0]  addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge CLK);
    IOAddr = a;
    IOWriteData = d;
    IOWriteEn = 1'b1;
    @(negedge CLK);
    IOWriteEn = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
    IOAddr = a;
    #1;
    check(name, IOReadData, exp);
  endtask

  initial begin
    RESET = 1'b1;
    IOAddr = '0;
    IOWriteData = '0;
    IOWriteEn = 1'b0;
    SW = 8'h3C;
    BTN = 4'h0;

    tbl[0]  = '{4'h0, 1'b0, 32'h0,         32'h0};
    tbl[1]  = '{4'h1, 1'b0, 32'h0,         32'h0};
    tbl[2]  = '{4'h2, 1'b0, 32'h0,         32'h0000_003C};
    tbl[3]  = '{4'h3, 1'b0, 32'h0,         32'h0};
    tbl[4]  = '{4'h4, 1'b0, 32'h0,         32'h0};
    tbl[5]  = '{4'h5, 1'b0, 32'h0,         32'h000F_4240};
    tbl[6]  = '{4'h7, 1'b0, 32'h0,         32'h0};
    tbl[7]  = '{4'hF, 1'b0, 32'h0,         32'h0};
    tbl[8]  = '{4'h0, 1'b1, 32'h0000_00A5, 32'h0};
    tbl[9]  = '{4'h0, 1'b0, 32'h0,         32'h0000_00A5};
    tbl[10] = '{4'h1, 1'b1, 32'h1234_BEEF, 32'h0};
    tbl[11] = '{4'h1, 1'b0, 32'h0,         32'h0000_BEEF};
    tbl[12] = '{4'h2, 1'b1, 32'h0000_00FF, 32'h0000_003C};
    tbl[13] = '{4'h2, 1'b0, 32'h0,         32'h0000_003C};
    tbl[14] = '{4'h7, 1'b1, 32'hDEAD_BEEF, 32'h0};
    tbl[15] = '{4'h7, 1'b0, 32'h0,         32'h0};
    tbl[16] = '{4'h5, 1'b1, 32'hFFFF_FFFF, 32'h000F_4240};
    tbl[17] = '{4'h5, 1'b0, 32'h0,         32'h00FF_FFFF};
    tbl[18] = '{4'h0, 1'b1, 32'h0000_01FF, 32'h0000_00A5};
    tbl[19] = '{4'h0, 1'b0, 32'h0,         32'h0000_00FF};

    repeat (3) @(negedge CLK);
    RESET = 1'b0;

    // Register map: reset values, writes, same-cycle old-value reads.
    for (int i = 0; i < NV; i++) begin
      @(negedge CLK);
      IOAddr = tbl[i].addr;
      IOWriteData = tbl[i].wd;
      IOWriteEn = tbl[i].we;
      #1;
      check($sformatf("vec%0d", i), IOReadData, tbl[i].exp);
    end
    @(negedge CLK);
    IOWriteEn = 1'b0;
    #1;
    check("led_port", 32'(LED), 32'h0000_00FF);
    check("seg_port", 32'(SEG), 32'h0000_BEEF);

    // Button event latch and W1C.
    BTN = 4'h4;
    repeat (5) @(negedge CLK);
    BTN = 4'h0;
    rd_chk("btnev_set", 4'h3, 32'h4);
    wr(4'h3, 32'h4);
    rd_chk("btnev_clr", 4'h3, 32'h0);
    repeat (4) @(negedge CLK);
    BTN = 4'h4;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    IOAddr = 4'h3;
    IOWriteData = 32'h4;
    IOWriteEn = 1'b1;
    @(negedge CLK);
    IOWriteEn = 1'b0;
    BTN = 4'h0;
    rd_chk("btnev_set_wins", 4'h3, 32'h4);

    // Prescaler with DIV=3.
    wr(4'h4, 32'h0);
    wr(4'h5, 32'h3);
    for (int i = 1; i <= 12; i++) begin
      @(posedge CLK);
      #1;
      check($sformatf("tick_div3_c%0d", i), 32'(TICK), (i % 3 == 0) ? 32'h1 : 32'h0);
    end
    rd_chk("tickcnt_div3", 4'h4, 32'h4);

    // DIV=0 ticks every cycle.
    wr(4'h5, 32'h0);
    check("tick_div0_wr", 32'(TICK), 32'h0);
    for (int i = 1; i <= 4; i++) begin
      @(posedge CLK);
      #1;
      check($sformatf("tick_div0_c%0d", i), 32'(TICK), 32'h1);
    end

    // TICKCNT wrap and clear-on-tick with DIV=1.
    wr(4'h5, 32'h1);
    @(negedge CLK);
    force dut.tickcnt = 32'hFFFF_FFFE;
    #1;
    release dut.tickcnt;
    rd_chk("tickcnt_preset", 4'h4, 32'hFFFF_FFFE);
    @(posedge CLK);
    rd_chk("tickcnt_max", 4'h4, 32'hFFFF_FFFF);
    @(posedge CLK);
    rd_chk("tickcnt_wrap", 4'h4, 32'h0);
    @(posedge CLK);
    rd_chk("tickcnt_after_wrap", 4'h4, 32'h1);
    wr(4'h4, 32'h0);
    check("tick_on_clear", 32'(TICK), 32'h1);
    rd_chk("tickcnt_clear_on_tick", 4'h4, 32'h0);

    // Asynchronous reset mid-prescale.
    wr(4'h0, 32'hFF);
    #2;
    check("tick_pre_rst", 32'(TICK), 32'h1);
    check("led_pre_rst", 32'(LED), 32'h0000_00FF);
    RESET = 1'b1;
    #1;
    check("led_async_rst", 32'(LED), 32'h0);
    check("seg_async_rst", 32'(SEG), 32'h0);
    check("tick_async_rst", 32'(TICK), 32'h0);
    rd_chk("div_async_rst", 4'h5, 32'h000F_4240);
    rd_chk("tickcnt_async_rst", 4'h4, 32'h0);
    IOAddr = 4'h0;
    IOWriteData = 32'h55;
    IOWriteEn = 1'b1;
    @(posedge CLK);
    #1;
    check("led_write_in_rst", 32'(LED), 32'h0);
    @(negedge CLK);
    RESET = 1'b0;
    IOWriteEn = 1'b0;
`ifdef IO_RESPONDER_LFSR_EN
    rd_chk("rand_seed", 4'h6, 32'h0000_ACE1);
    @(posedge CLK);
    #1;
    check("tick_first_cycle", 32'(TICK), 32'h0);
    rd_chk("rand_step1", 4'h6, 32'h0000_59C3);
    @(posedge CLK);
    rd_chk("rand_step2", 4'h6, 32'h0000_B387);
`else
    rd_chk("rand_off", 4'h6, 32'h0);
    @(posedge CLK);
    #1;
    check("tick_first_cycle", 32'(TICK), 32'h0);
    rd_chk("rand_off_later", 4'h6, 32'h0);
`endif
    rd_chk("led_after_rst", 4'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
